// File: rtl/sprite_rom_arbiter_if.sv
// Request/ROM/response bundle between the sprite renderers, the shared ROM and the arbiter.
// The master side drives requests and ROM data; the slave side is the arbiter.
interface sprite_rom_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic                      enable;
  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ*ADDR_W-1:0]   req_addr;
  logic [N_REQ-1:0]          req_ready;
  logic [ADDR_W-1:0]         rom_address;
  logic [DATA_W-1:0]         rom_q;
  logic [N_REQ-1:0]          rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      busy;

  modport master (
    output enable, req_valid, req_addr, rom_q,
    input  req_ready, rom_address, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  enable, req_valid, req_addr, rom_q,
    output req_ready, rom_address, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin share of one sprite ROM; response is strobed ROM_LAT+1 edges after the accept edge.
// One accept per cycle, req_ready gated only by enable; responses are never stalled.
module sprite_rom_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1
) (
  input  logic                 vga_clk,
  input  logic                 reset_n,
  sprite_rom_arbiter_if.slave  bus
);
  localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int STAGES = ROM_LAT + 1;
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);
  localparam logic [PTR_W-1:0] LAST_ID  = PTR_W'(N_REQ - 1);

  logic [ADDR_W-1:0] addr_arr [N_REQ];
  logic [PTR_W-1:0]  ptr_q;
  logic [PTR_W-1:0]  ptr_next;
  logic              grant_any;
  logic [PTR_W-1:0]  grant_id;
  logic [N_REQ-1:0]  grant_vec;

  logic [STAGES-1:0] tag_vld;
  logic [PTR_W-1:0]  tag_id [STAGES];

  logic [ADDR_W-1:0] rom_address_q;
  logic [N_REQ-1:0]  rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;

  for (genvar g = 0; g < N_REQ; g++) begin : g_addr
    assign addr_arr[g] = bus.req_addr[g*ADDR_W +: ADDR_W];
  end

  // Two passes give the wrapped search: first the indices at or above the
  // pointer, then everything from 0 (upper hits are already taken by then).
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    grant_vec = '0;
    if (bus.enable) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!grant_any && (i >= int'(ptr_q)) && bus.req_valid[i]) begin
          grant_any = 1'b1;
          grant_id  = PTR_W'(i);
        end
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (!grant_any && bus.req_valid[i]) begin
          grant_any = 1'b1;
          grant_id  = PTR_W'(i);
        end
      end
      if (grant_any) begin
        grant_vec = ONE_HOT0 << grant_id;
      end
    end
  end

  always_comb begin
    ptr_next = ptr_q;
    if (grant_any) begin
      ptr_next = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q         <= '0;
      rom_address_q <= '0;
      tag_vld       <= '0;
      for (int s = 0; s < STAGES; s++) begin
        tag_id[s] <= '0;
      end
    end else begin
      ptr_q <= ptr_next;
      if (grant_any) begin
        rom_address_q <= addr_arr[grant_id];
      end
      tag_vld   <= {tag_vld[STAGES-2:0], grant_any};
      tag_id[0] <= grant_id;
      for (int s = 1; s < STAGES; s++) begin
        tag_id[s] <= tag_id[s-1];
      end
    end
  end

  // The last tag stage lines up with the ROM word for that address.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else if (tag_vld[STAGES-1]) begin
      rsp_valid_q <= ONE_HOT0 << tag_id[STAGES-1];
      rsp_data_q  <= bus.rom_q;
    end else begin
      rsp_valid_q <= '0;
    end
  end

  assign bus.req_ready   = grant_vec;
  assign bus.rom_address = rom_address_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.busy        = |tag_vld;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed-vector bench for sprite_rom_arbiter with a 1-cycle ROM returning addr[7:0]^8'hA5.
module tb_sprite_rom_arbiter;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  sprite_rom_arbiter_if #(.N_REQ(4), .ADDR_W(10), .DATA_W(8)) bus ();

  sprite_rom_arbiter #(.N_REQ(4), .ADDR_W(10), .DATA_W(8), .ROM_LAT(1)) dut (
    .vga_clk (clk),
    .reset_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bus.rom_q <= bus.rom_address[7:0] ^ 8'hA5;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] vld;
    logic [9:0] a0, a1, a2, a3;
    logic [3:0] e_rdy;
    logic [9:0] e_rom;
    logic       e_busy;
    logic [3:0] e_rv;
    logic [7:0] e_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic e, input logic [3:0] v,
                              input logic [9:0] a0, input logic [9:0] a1,
                              input logic [9:0] a2, input logic [9:0] a3,
                              input logic [3:0] rdy, input logic [9:0] rom,
                              input logic bsy, input logic [3:0] rv, input logic [7:0] rd);
    vec_t t;
    t.rst = r; t.en = e; t.vld = v;
    t.a0 = a0; t.a1 = a1; t.a2 = a2; t.a3 = a3;
    t.e_rdy = rdy; t.e_rom = rom; t.e_busy = bsy; t.e_rv = rv; t.e_rd = rd;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0h, expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [3:0] vld,
                       input logic [9:0] a0, input logic [9:0] a1,
                       input logic [9:0] a2, input logic [9:0] a3);
    bus.enable    = en;
    bus.req_valid = vld;
    bus.req_addr  = {a3, a2, a1, a0};
  endtask

  task automatic apply_reset();
    drive(1'b1, 4'b0000, 10'd0, 10'd0, 10'd0, 10'd0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_outputs(input string tag, input int idx, input logic [9:0] rom,
                             input logic bsy, input logic [3:0] rv, input logic [7:0] rd);
    chk({tag, "_rom_address"}, idx, 16'(bus.rom_address), 16'(rom));
    chk({tag, "_busy"},        idx, 16'(bus.busy),        16'(bsy));
    chk({tag, "_rsp_valid"},   idx, 16'(bus.rsp_valid),   16'(rv));
    chk({tag, "_rsp_data"},    idx, 16'(bus.rsp_data),    16'(rd));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    drive(1'b1, 4'b0000, 10'd0, 10'd0, 10'd0, 10'd0);
    #1;
    chk_outputs("reset", 0, 10'd0, 1'b0, 4'b0000, 8'h00);

    // Single request: addr 5 -> A0 three edges later.
    add(1,1,4'b0001, 10'd5,0,0,0, 4'b0001, 10'd5, 1, 4'b0000, 8'h00);
    add(0,1,4'b0000, 10'd5,0,0,0, 4'b0000, 10'd5, 1, 4'b0000, 8'h00);
    add(0,1,4'b0000, 10'd5,0,0,0, 4'b0000, 10'd5, 0, 4'b0001, 8'hA0);
    add(0,1,4'b0000, 10'd5,0,0,0, 4'b0000, 10'd5, 0, 4'b0000, 8'hA0);
    // Full contention from pointer 0.
    add(1,1,4'b1111, 'h00,'h10,'h20,'h30, 4'b0001, 'h00, 1, 4'b0000, 8'h00);
    add(0,1,4'b1111, 'h00,'h10,'h20,'h30, 4'b0010, 'h10, 1, 4'b0000, 8'h00);
    add(0,1,4'b1111, 'h00,'h10,'h20,'h30, 4'b0100, 'h20, 1, 4'b0001, 8'hA5);
    add(0,1,4'b1111, 'h00,'h10,'h20,'h30, 4'b1000, 'h30, 1, 4'b0010, 8'hB5);
    add(0,1,4'b1111, 'h00,'h10,'h20,'h30, 4'b0001, 'h00, 1, 4'b0100, 8'h85);
    add(0,1,4'b1111, 'h00,'h10,'h20,'h30, 4'b0010, 'h10, 1, 4'b1000, 8'h95);
    add(0,1,4'b0000, 'h00,'h10,'h20,'h30, 4'b0000, 'h10, 1, 4'b0001, 8'hA5);
    add(0,1,4'b0000, 'h00,'h10,'h20,'h30, 4'b0000, 'h10, 0, 4'b0010, 8'hB5);
    add(0,1,4'b0000, 'h00,'h10,'h20,'h30, 4'b0000, 'h10, 0, 4'b0000, 8'hB5);
    // Fairness: only 1 and 3 requesting.
    add(1,1,4'b1010, 0,'h11,0,'h33, 4'b0010, 'h11, 1, 4'b0000, 8'h00);
    add(0,1,4'b1010, 0,'h11,0,'h33, 4'b1000, 'h33, 1, 4'b0000, 8'h00);
    add(0,1,4'b1010, 0,'h11,0,'h33, 4'b0010, 'h11, 1, 4'b0010, 8'hB4);
    add(0,1,4'b1010, 0,'h11,0,'h33, 4'b1000, 'h33, 1, 4'b1000, 8'h96);
    add(0,1,4'b0000, 0,'h11,0,'h33, 4'b0000, 'h33, 1, 4'b0010, 8'hB4);
    add(0,1,4'b0000, 0,'h11,0,'h33, 4'b0000, 'h33, 0, 4'b1000, 8'h96);
    // Enable gating after two accepts, resume at requester 2.
    add(1,1,4'b1111, 'h00,'h10,'h20,'h30, 4'b0001, 'h00, 1, 4'b0000, 8'h00);
    add(0,1,4'b1111, 'h00,'h10,'h20,'h30, 4'b0010, 'h10, 1, 4'b0000, 8'h00);
    add(0,0,4'b1111, 'h00,'h10,'h20,'h30, 4'b0000, 'h10, 1, 4'b0001, 8'hA5);
    add(0,0,4'b1111, 'h00,'h10,'h20,'h30, 4'b0000, 'h10, 0, 4'b0010, 8'hB5);
    add(0,0,4'b1111, 'h00,'h10,'h20,'h30, 4'b0000, 'h10, 0, 4'b0000, 8'hB5);
    add(0,1,4'b1111, 'h00,'h10,'h20,'h30, 4'b0100, 'h20, 1, 4'b0000, 8'hB5);
    add(0,1,4'b1111, 'h00,'h10,'h20,'h30, 4'b1000, 'h30, 1, 4'b0000, 8'hB5);
    add(0,0,4'b0000, 'h00,'h10,'h20,'h30, 4'b0000, 'h30, 1, 4'b0100, 8'h85);
    add(0,0,4'b0000, 'h00,'h10,'h20,'h30, 4'b0000, 'h30, 0, 4'b1000, 8'h95);
    // Back-to-back single requester 2, addresses 0..7.
    add(1,1,4'b0100, 0,0,10'd0,0, 4'b0100, 10'd0, 1, 4'b0000, 8'h00);
    add(0,1,4'b0100, 0,0,10'd1,0, 4'b0100, 10'd1, 1, 4'b0000, 8'h00);
    add(0,1,4'b0100, 0,0,10'd2,0, 4'b0100, 10'd2, 1, 4'b0100, 8'hA5);
    add(0,1,4'b0100, 0,0,10'd3,0, 4'b0100, 10'd3, 1, 4'b0100, 8'hA4);
    add(0,1,4'b0100, 0,0,10'd4,0, 4'b0100, 10'd4, 1, 4'b0100, 8'hA7);
    add(0,1,4'b0100, 0,0,10'd5,0, 4'b0100, 10'd5, 1, 4'b0100, 8'hA6);
    add(0,1,4'b0100, 0,0,10'd6,0, 4'b0100, 10'd6, 1, 4'b0100, 8'hA1);
    add(0,1,4'b0100, 0,0,10'd7,0, 4'b0100, 10'd7, 1, 4'b0100, 8'hA0);
    add(0,1,4'b0000, 0,0,10'd7,0, 4'b0000, 10'd7, 1, 4'b0100, 8'hA3);
    add(0,1,4'b0000, 0,0,10'd7,0, 4'b0000, 10'd7, 0, 4'b0100, 8'hA2);
    add(0,1,4'b0000, 0,0,10'd7,0, 4'b0000, 10'd7, 0, 4'b0000, 8'hA2);

    for (int r = 0; r < vecs.size(); r++) begin
      if (vecs[r].rst) apply_reset();
      @(negedge clk);
      drive(vecs[r].en, vecs[r].vld, vecs[r].a0, vecs[r].a1, vecs[r].a2, vecs[r].a3);
      #1;
      chk("vec_req_ready", r, 16'(bus.req_ready), 16'(vecs[r].e_rdy));
      @(posedge clk);
      #1;
      chk_outputs("vec", r, vecs[r].e_rom, vecs[r].e_busy, vecs[r].e_rv, vecs[r].e_rd);
    end

    // Reset mid-flight: pointer sits at 3, so requester 0 wins via wrap.
    @(negedge clk);
    drive(1'b1, 4'b0001, 10'h2C, 10'd0, 10'd0, 10'd0);
    #1;
    chk("mid_req_ready", 0, 16'(bus.req_ready), 16'h0001);
    @(posedge clk);
    #1;
    chk_outputs("mid_accept", 0, 10'h2C, 1'b1, 4'b0000, 8'hA2);
    @(negedge clk);
    drive(1'b1, 4'b0000, 10'h2C, 10'd0, 10'd0, 10'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_outputs("mid_in_reset", 0, 10'd0, 1'b0, 4'b0000, 8'h00);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk("post_reset_rsp_valid", c, 16'(bus.rsp_valid), 16'h0000);
      chk("post_reset_busy",      c, 16'(bus.busy),      16'h0000);
    end
    @(negedge clk);
    drive(1'b1, 4'b1111, 10'h2C, 10'h10, 10'h20, 10'h30);
    #1;
    chk("post_reset_req_ready", 0, 16'(bus.req_ready), 16'h0001);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 4'b0000, 10'h2C, 10'h10, 10'h20, 10'h30);
    repeat (2) @(posedge clk);
    #1;
    chk_outputs("post_reset_rsp", 0, 10'h2C, 1'b0, 4'b0001, 8'h89);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
